// File: rtl/usbh_report_decoder_gen_if.sv
// usbh_report_decoder_gen_if: HID report strobe in, NES pad state out.
interface usbh_report_decoder_gen_if;
    logic [63:0] i_report;
    logic        i_report_valid;
    logic [7:0]  o_btn;
    logic [1:0]  o_turbo;
    logic        o_connected;
    modport master (output i_report, i_report_valid, input o_btn, o_turbo, o_connected);
    modport slave  (input i_report, i_report_valid, output o_btn, o_turbo, o_connected);
endinterface

// File: rtl/usbh_report_decoder_gen.sv
// usbh_report_decoder_gen: HID gamepad report to NES buttons with hat/axis decode,
// SOCD cleaning, turbo autofire and report-loss timeout.
module usbh_report_decoder_gen #(
    parameter int         c_clk_hz       = 6000000,
    parameter int         c_autofire_hz  = 10,
    parameter int         c_timeout_ms   = 100,
    parameter int         c_x_byte       = 1,
    parameter int         c_y_byte       = 2,
    parameter int         c_hat_bit      = 60,
    parameter int         c_a_bit        = 46,
    parameter int         c_b_bit        = 48,
    parameter int         c_sel_bit      = 54,
    parameter int         c_start_bit    = 55,
    parameter int         c_ta_bit       = 52,
    parameter int         c_tb_bit       = 53,
    parameter logic [7:0] c_axis_lo      = 8'h40,
    parameter logic [7:0] c_axis_hi      = 8'hC0,
    parameter logic [7:0] c_hyst         = 8'h10,
    parameter bit         c_socd_neutral = 1'b1
) (
    input logic                      i_clk,
    input logic                      i_rstn,
    usbh_report_decoder_gen_if.slave bus
);
    localparam int c_half   = c_clk_hz / (2 * c_autofire_hz);
    localparam int c_ms_div = c_clk_hz / 1000;
    localparam int aw       = $clog2(c_half + 1);
    localparam int pw       = $clog2(c_ms_div + 1);
    localparam int mw       = $clog2(c_timeout_ms + 1);

    logic [7:0]    x_q, y_q;
    logic [3:0]    hat_q, key_q;
    logic [1:0]    tb_q;
    logic          vld;
    logic [aw-1:0] af_cnt;
    logic          phase;
    logic [pw-1:0] pre;
    logic [mw-1:0] ms;
    logic          conn;
    logic [3:0]    hat_dir, axis, keys;
    logic [1:0]    turbo, turbo_prev;
    logic [3:0]    hat_dec, axis_nxt, dir_raw, dir;
    logic          expire;

    // Direction vectors are {R,L,D,U}; keys are {start,select,B,A}
    always_comb begin
        hat_dec = {hat_q inside {4'd1, 4'd2, 4'd3}, hat_q inside {4'd5, 4'd6, 4'd7},
                   hat_q inside {4'd3, 4'd4, 4'd5}, hat_q inside {4'd7, 4'd0, 4'd1}};
        axis_nxt[3] = x_q > c_axis_hi ? 1'b1 : x_q <= c_axis_hi - c_hyst ? 1'b0 : axis[3];
        axis_nxt[2] = x_q < c_axis_lo ? 1'b1 : x_q >= c_axis_lo + c_hyst ? 1'b0 : axis[2];
        axis_nxt[1] = y_q > c_axis_hi ? 1'b1 : y_q <= c_axis_hi - c_hyst ? 1'b0 : axis[1];
        axis_nxt[0] = y_q < c_axis_lo ? 1'b1 : y_q >= c_axis_lo + c_hyst ? 1'b0 : axis[0];
        dir_raw = hat_dir | axis;
        dir = {c_socd_neutral && dir_raw[3] && dir_raw[2] ? 2'b00 : dir_raw[3:2],
               c_socd_neutral && dir_raw[1] && dir_raw[0] ? 2'b00 : dir_raw[1:0]};
        // A fresh report in the expiry cycle wins over the drop
        expire = ms == mw'(c_timeout_ms) && !bus.i_report_valid;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            x_q        <= '0;
            y_q        <= '0;
            hat_q      <= '0;
            key_q      <= '0;
            tb_q       <= '0;
            vld        <= 1'b0;
            af_cnt     <= '0;
            phase      <= 1'b0;
            pre        <= '0;
            ms         <= '0;
            conn       <= 1'b0;
            hat_dir    <= '0;
            axis       <= '0;
            keys       <= '0;
            turbo      <= '0;
            turbo_prev <= '0;
            bus.o_btn  <= '0;
        end else begin
            vld <= bus.i_report_valid;
            if (bus.i_report_valid) begin
                x_q   <= bus.i_report[c_x_byte*8 +: 8];
                y_q   <= bus.i_report[c_y_byte*8 +: 8];
                hat_q <= bus.i_report[c_hat_bit +: 4];
                key_q <= {bus.i_report[c_start_bit], bus.i_report[c_sel_bit],
                          bus.i_report[c_b_bit], bus.i_report[c_a_bit]};
                tb_q  <= {bus.i_report[c_tb_bit], bus.i_report[c_ta_bit]};
            end
            af_cnt <= af_cnt == aw'(c_half - 1) ? '0 : af_cnt + 1'b1;
            if (af_cnt == aw'(c_half - 1))
                phase <= ~phase;
            if (bus.i_report_valid) begin
                pre  <= '0;
                ms   <= '0;
                conn <= 1'b1;
            end else begin
                pre <= pre == pw'(c_ms_div - 1) ? '0 : pre + 1'b1;
                if (pre == pw'(c_ms_div - 1) && ms != mw'(c_timeout_ms))
                    ms <= ms + 1'b1;
            end
            if (expire) begin
                conn       <= 1'b0;
                hat_dir    <= '0;
                axis       <= '0;
                keys       <= '0;
                turbo      <= '0;
                turbo_prev <= '0;
            end else if (vld) begin
                hat_dir    <= hat_dec;
                axis       <= axis_nxt;
                keys       <= key_q;
                turbo      <= turbo ^ (tb_q & ~turbo_prev);
                turbo_prev <= tb_q;
            end
            bus.o_btn <= expire || !conn ? '0 :
                         {dir, keys[3:2], keys[1] | (turbo[1] & phase), keys[0] | (turbo[0] & phase)};
        end
    end

    assign bus.o_turbo     = turbo;
    assign bus.o_connected = conn;
endmodule

// File: tb/tb_usbh_report_decoder_gen.sv
// tb_usbh_report_decoder_gen: directed checks of decode, hysteresis, SOCD, turbo,
// autofire, timeout and reset, on scaled-down clock/timeout parameters.
module tb_usbh_report_decoder_gen;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    usbh_report_decoder_gen_if bus0 ();
    usbh_report_decoder_gen_if bus1 ();

    // Scaled: ms = 20 clocks, timeout = 100 clocks, autofire half period = 10 clocks
    usbh_report_decoder_gen #(.c_clk_hz(20000), .c_autofire_hz(1000), .c_timeout_ms(5))
        dut0 (.i_clk(clk), .i_rstn(rstn), .bus(bus0.slave));
    usbh_report_decoder_gen #(.c_clk_hz(20000), .c_autofire_hz(1000), .c_timeout_ms(5),
                              .c_socd_neutral(1'b0))
        dut1 (.i_clk(clk), .i_rstn(rstn), .bus(bus1.slave));

    assign bus1.i_report       = bus0.i_report;
    assign bus1.i_report_valid = bus0.i_report_valid;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk(input logic [7:0] x, input logic [7:0] y,
                                       input logic [3:0] hat, input logic [3:0] keys,
                                       input logic [1:0] tbt);
        logic [63:0] r;
        r = '0;
        r[15:8]  = x;
        r[23:16] = y;
        r[63:60] = hat;
        r[46] = keys[0];
        r[48] = keys[1];
        r[54] = keys[2];
        r[55] = keys[3];
        r[52] = tbt[0];
        r[53] = tbt[1];
        return r;
    endfunction

    task automatic send(input logic [63:0] r);
        @(negedge clk);
        bus0.i_report       = r;
        bus0.i_report_valid = 1'b1;
        @(negedge clk);
        bus0.i_report_valid = 1'b0;
    endtask

    task automatic test_reset;
        bus0.i_report = '0;
        bus0.i_report_valid = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({bus0.o_btn, bus0.o_turbo, bus0.o_connected} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_hold got btn=%h turbo=%b conn=%b want 00/00/0", bus0.o_btn, bus0.o_turbo, bus0.o_connected);
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if ({bus0.o_btn, bus0.o_turbo, bus0.o_connected} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_release got btn=%h turbo=%b conn=%b want 00/00/0", bus0.o_btn, bus0.o_turbo, bus0.o_connected);
        end
    endtask

    task automatic test_hat;
        logic [7:0] hat_exp [16];
        hat_exp = '{8'h10, 8'h90, 8'h80, 8'hA0, 8'h20, 8'h60, 8'h40, 8'h50,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) begin
            send(mk(8'h80, 8'h80, 4'(i), 4'h0, 2'b00));
            repeat (2) @(negedge clk);
            nvec++;
            if (bus0.o_btn !== hat_exp[i]) begin
                nerr++;
                $display("FAIL hat_%0d got %h want %h", i, bus0.o_btn, hat_exp[i]);
            end
        end
        nvec++;
        if (bus0.o_connected !== 1'b1) begin
            nerr++;
            $display("FAIL connected_after_reports got %b want 1", bus0.o_connected);
        end
    endtask

    task automatic test_buttons;
        logic [3:0] k [6];
        logic [3:0] h [6];
        logic [7:0] e [6];
        k = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h1};
        h = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h2};
        e = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, 8'h81};
        for (int i = 0; i < 6; i++) begin
            send(mk(8'h80, 8'h80, h[i], k[i], 2'b00));
            repeat (2) @(negedge clk);
            nvec++;
            if (bus0.o_btn !== e[i]) begin
                nerr++;
                $display("FAIL button_%0d got %h want %h", i, bus0.o_btn, e[i]);
            end
        end
        send(mk(8'h80, 8'h80, 4'hF, 4'h0, 2'b00));
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency;
        send(mk(8'h80, 8'h80, 4'h2, 4'h0, 2'b00));
        @(negedge clk);
        nvec++;
        if (bus0.o_btn !== 8'h00) begin
            nerr++;
            $display("FAIL latency_early got %h want 00", bus0.o_btn);
        end
        @(negedge clk);
        nvec++;
        if (bus0.o_btn !== 8'h80) begin
            nerr++;
            $display("FAIL latency_n2 got %h want 80", bus0.o_btn);
        end
        send(mk(8'h80, 8'h80, 4'hF, 4'h0, 2'b00));
        repeat (2) @(negedge clk);
        nvec++;
        if (bus0.o_btn !== 8'h00) begin
            nerr++;
            $display("FAIL hat_none got %h want 00", bus0.o_btn);
        end
    endtask

    task automatic test_hyst;
        logic [7:0] hx [13];
        logic [7:0] hy [13];
        logic [7:0] he [13];
        hx = '{8'h80, 8'h3F, 8'h45, 8'h50, 8'hC1, 8'hB8, 8'hB0,
               8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        hy = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
               8'h3F, 8'h4F, 8'h50, 8'hFF, 8'hB1, 8'hB0};
        he = '{8'h00, 8'h40, 8'h40, 8'h00, 8'h80, 8'h80, 8'h00,
               8'h10, 8'h10, 8'h00, 8'h20, 8'h20, 8'h00};
        for (int i = 0; i < 13; i++) begin
            send(mk(hx[i], hy[i], 4'hF, 4'h0, 2'b00));
            repeat (2) @(negedge clk);
            nvec++;
            if (bus0.o_btn !== he[i]) begin
                nerr++;
                $display("FAIL hyst_%0d x=%h y=%h got %h want %h", i, hx[i], hy[i], bus0.o_btn, he[i]);
            end
        end
    endtask

    task automatic test_socd;
        send(mk(8'h80, 8'hFF, 4'h0, 4'h0, 2'b00));
        repeat (2) @(negedge clk);
        nvec++;
        if (bus0.o_btn !== 8'h00) begin
            nerr++;
            $display("FAIL socd_ud_neutral got %h want 00", bus0.o_btn);
        end
        nvec++;
        if (bus1.o_btn !== 8'h30) begin
            nerr++;
            $display("FAIL socd_ud_passthru got %h want 30", bus1.o_btn);
        end
        send(mk(8'h3F, 8'h80, 4'h2, 4'h0, 2'b00));
        repeat (2) @(negedge clk);
        nvec++;
        if (bus0.o_btn !== 8'h00) begin
            nerr++;
            $display("FAIL socd_lr_neutral got %h want 00", bus0.o_btn);
        end
        nvec++;
        if (bus1.o_btn !== 8'hC0) begin
            nerr++;
            $display("FAIL socd_lr_passthru got %h want c0", bus1.o_btn);
        end
        send(mk(8'h80, 8'h80, 4'hF, 4'h0, 2'b00));
        repeat (2) @(negedge clk);
        nvec++;
        if (bus1.o_btn !== 8'h00) begin
            nerr++;
            $display("FAIL socd_release got %h want 00", bus1.o_btn);
        end
    endtask

    task automatic test_turbo;
        logic       ta [5];
        logic [1:0] te [5];
        ta = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        te = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            send(mk(8'h80, 8'h80, 4'hF, 4'h0, {1'b0, ta[i]}));
            repeat (2) @(negedge clk);
            nvec++;
            if (bus0.o_turbo !== te[i]) begin
                nerr++;
                $display("FAIL turbo_seq_%0d got %b want %b", i, bus0.o_turbo, te[i]);
            end
        end
    endtask

    task automatic test_autofire;
        logic last;
        int   since;
        int   toggles;
        bit   seen;
        bit   ok;
        send(mk(8'h80, 8'h80, 4'hF, 4'h0, 2'b00));
        send(mk(8'h80, 8'h80, 4'hF, 4'h0, 2'b01));
        repeat (2) @(negedge clk);
        nvec++;
        if (bus0.o_turbo !== 2'b01) begin
            nerr++;
            $display("FAIL autofire_latch got %b want 01", bus0.o_turbo);
        end
        last = bus0.o_btn[0];
        since = 0;
        toggles = 0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            since++;
            if (bus0.o_btn[0] !== last) begin
                if (seen) begin
                    nvec++;
                    if (since != 10) begin
                        nerr++;
                        $display("FAIL autofire_half_period got %0d clocks want 10", since);
                    end
                end
                seen = 1;
                since = 0;
                toggles++;
                last = bus0.o_btn[0];
            end
        end
        nvec++;
        if (toggles < 7) begin
            nerr++;
            $display("FAIL autofire_toggles got %0d want >=7", toggles);
        end
        send(mk(8'h80, 8'h80, 4'hF, 4'h1, 2'b00));
        repeat (2) @(negedge clk);
        ok = 1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus0.o_btn !== 8'h01) ok = 0;
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL autofire_with_a got %h want steady 01", bus0.o_btn);
        end
        send(mk(8'h80, 8'h80, 4'hF, 4'h0, 2'b01));
        send(mk(8'h80, 8'h80, 4'hF, 4'h0, 2'b00));
        repeat (2) @(negedge clk);
        nvec++;
        if (bus0.o_turbo !== 2'b00) begin
            nerr++;
            $display("FAIL autofire_unlatch got %b want 00", bus0.o_turbo);
        end
        ok = 1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus0.o_btn !== 8'h00) ok = 0;
        end
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL autofire_off got %h want steady 00", bus0.o_btn);
        end
    endtask

    task automatic test_timeout;
        send(mk(8'h80, 8'h80, 4'hF, 4'h1, 2'b10));
        repeat (2) @(negedge clk);
        nvec++;
        if (bus0.o_btn[0] !== 1'b1 || bus0.o_turbo !== 2'b10) begin
            nerr++;
            $display("FAIL timeout_setup got btn=%h turbo=%b want a=1 turbo=10", bus0.o_btn, bus0.o_turbo);
        end
        repeat (93) @(negedge clk);
        nvec++;
        if (bus0.o_connected !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_early got conn=%b want 1", bus0.o_connected);
        end
        repeat (10) @(negedge clk);
        nvec++;
        if ({bus0.o_connected, bus0.o_btn, bus0.o_turbo} !== 11'd0) begin
            nerr++;
            $display("FAIL timeout_drop got conn=%b btn=%h turbo=%b want 0/00/00", bus0.o_connected, bus0.o_btn, bus0.o_turbo);
        end
        repeat (200) @(negedge clk);
        send(mk(8'h80, 8'h80, 4'hF, 4'h1, 2'b00));
        repeat (2) @(negedge clk);
        nvec++;
        if ({bus0.o_connected, bus0.o_btn, bus0.o_turbo} !== {1'b1, 8'h01, 2'b00}) begin
            nerr++;
            $display("FAIL timeout_restore got conn=%b btn=%h turbo=%b want 1/01/00", bus0.o_connected, bus0.o_btn, bus0.o_turbo);
        end
        repeat (97) @(negedge clk);
        send(mk(8'h80, 8'h80, 4'hF, 4'h1, 2'b00));
        nvec++;
        if (bus0.o_connected !== 1'b1) begin
            nerr++;
            $display("FAIL timeout_coincide got conn=%b want 1", bus0.o_connected);
        end
        repeat (50) @(negedge clk);
        nvec++;
        if (bus0.o_connected !== 1'b1 || bus0.o_btn !== 8'h01) begin
            nerr++;
            $display("FAIL timeout_coincide_hold got conn=%b btn=%h want 1/01", bus0.o_connected, bus0.o_btn);
        end
    endtask

    task automatic test_reset_mid;
        send(mk(8'h80, 8'h80, 4'hF, 4'h0, 2'b01));
        repeat (2) @(negedge clk);
        nvec++;
        if (bus0.o_turbo !== 2'b01) begin
            nerr++;
            $display("FAIL rstmid_latch got %b want 01", bus0.o_turbo);
        end
        @(negedge clk);
        bus0.i_report = mk(8'h80, 8'h80, 4'h2, 4'h1, 2'b00);
        bus0.i_report_valid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        nvec++;
        if ({bus0.o_btn, bus0.o_turbo, bus0.o_connected} !== 11'd0) begin
            nerr++;
            $display("FAIL rstmid_async got btn=%h turbo=%b conn=%b want 00/00/0", bus0.o_btn, bus0.o_turbo, bus0.o_connected);
        end
        @(negedge clk);
        bus0.i_report_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        nvec++;
        if ({bus0.o_btn, bus0.o_turbo, bus0.o_connected} !== 11'd0) begin
            nerr++;
            $display("FAIL rstmid_after got btn=%h turbo=%b conn=%b want 00/00/0", bus0.o_btn, bus0.o_turbo, bus0.o_connected);
        end
        send(mk(8'h80, 8'h80, 4'hF, 4'h1, 2'b00));
        repeat (2) @(negedge clk);
        nvec++;
        if ({bus0.o_btn, bus0.o_turbo, bus0.o_connected} !== {8'h01, 2'b00, 1'b1}) begin
            nerr++;
            $display("FAIL rstmid_resume got btn=%h turbo=%b conn=%b want 01/00/1", bus0.o_btn, bus0.o_turbo, bus0.o_connected);
        end
    endtask

    initial begin
        test_reset;
        test_hat;
        test_buttons;
        test_latency;
        test_hyst;
        test_socd;
        test_turbo;
        test_autofire;
        test_timeout;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/usbh_report_decoder_gen.md
USBH_REPORT_DECODER_GEN -- requirements
Module: usbh_report_decoder_gen

Interface
REQ-001 SHALL have parameter c_clk_hz, default 6000000, clock frequency in Hz.
REQ-002 SHALL have parameter c_autofire_hz, default 10, autofire square-wave frequency in Hz.
REQ-003 SHALL have parameter c_timeout_ms, default 100, report-loss timeout in ms.
REQ-004 SHALL have parameters c_x_byte, default 1, and c_y_byte, default 2, which give the byte index of the 8-bit unsigned X and Y axes in i_report.
REQ-005 SHALL have parameter c_hat_bit, default 60, the LSB index of the 4-bit hat nibble.
REQ-006 SHALL have parameters c_a_bit 46, c_b_bit 48, c_sel_bit 54, c_start_bit 55, c_ta_bit 52 and c_tb_bit 53 (defaults given), the bit indices of the A, B, select, start, turbo-A and turbo-B buttons.
REQ-007 SHALL have parameters c_axis_lo, default 8'h40, c_axis_hi, default 8'hC0, and c_hyst, default 8'h10, the axis thresholds and hysteresis; legal values satisfy c_axis_lo+c_hyst <= c_axis_hi-c_hyst.
REQ-008 SHALL have parameter c_socd_neutral, default 1; when set, opposing directions cancel.
REQ-009 SHALL have port i_clk, input, 1 bit, the single clock (USB core domain).
REQ-010 SHALL have port i_rstn, input, 1 bit, asynchronous active-low reset.
REQ-011 SHALL have port i_report, input, 64 bits, the HID report.
REQ-012 SHALL have port i_report_valid, input, 1 bit, a one-cycle strobe marking a new i_report.
REQ-013 SHALL have port o_btn, output, 8 bits, NES order {R,L,D,U,start,select,B,A}, active-high.
REQ-014 SHALL have port o_turbo, output, 2 bits, the turbo latch state {B,A}.
REQ-015 SHALL have port o_connected, output, 1 bit, high while reports are arriving within the timeout.

Function
REQ-016 SHALL sample i_report only in a cycle where i_report_valid=1, and SHALL update the decode registers at the next edge.
REQ-017 SHALL update o_btn one clock after the decode registers: valid at edge N gives new o_btn at edge N+2.
REQ-018 SHALL decode the hat as 0=U, 1=UR, 2=R, 3=DR, 4=D, 5=DL, 6=L, 7=UL, and 8..15 as none.
REQ-019 SHALL implement each axis direction as a hysteresis flag: L sets when X<c_axis_lo and clears when X>=c_axis_lo+c_hyst; R sets when X>c_axis_hi and clears when X<=c_axis_hi-c_hyst; U/D follow the same rules on Y; values between the set and clear points hold the flag.
REQ-020 SHALL form each direction output as the OR of the hat decode and the axis flag.
REQ-021 SHALL, when c_socd_neutral=1 and both U and D (or both L and R) are set, drive both bits of that pair to 0.
REQ-022 SHALL run the autofire phase counter freely from reset, toggling phase every c_clk_hz/(2*c_autofire_hz) clocks (integer division) and wrapping to 0.
REQ-023 SHALL implement turbo latches: a rising edge of the turbo-A bit between consecutive valid reports toggles o_turbo[0]; turbo-B toggles o_turbo[1] the same way; holding the button does not re-toggle.
REQ-024 SHALL drive o_btn[0] = A_button OR (o_turbo[0] AND phase), and o_btn[1] = B_button OR (o_turbo[1] AND phase).
REQ-025 SHALL time out using a ms prescaler (c_clk_hz/1000 clocks) and a ms counter; each valid report clears both and sets o_connected=1.
REQ-026 SHALL, when the ms counter reaches c_timeout_ms, set o_connected=0 and clear o_btn, the axis flags, the turbo latches and the previous-turbo register, all within 1 clock.
REQ-027 SHALL, if a valid report arrives in the same cycle as timeout expiry, give the valid report priority (no clear, counter reset).
REQ-028 SHALL saturate the ms counter at c_timeout_ms while disconnected, with no wrap.

Reset
REQ-029 SHALL, while i_rstn=0, asynchronously hold o_btn=0, o_turbo=0, o_connected=0, all counters at 0 and all axis flags at 0.
REQ-030 SHALL resume normal operation on the first clock after i_rstn deasserts, discarding any report in flight during reset.

Verification
REQ-031 Hat=4'h2 with axes 8'h80 -> o_btn=8'h80 two clocks after valid; hat=4'hF -> o_btn=8'h00.
REQ-032 X sequence 8'h80, 8'h3F, 8'h45, 8'h50 -> L = 0, 1, 1, 0.
REQ-033 Hat=0 (U) with Y=8'hFF (D), c_socd_neutral=1 -> o_btn[5:4]=2'b00; with c_socd_neutral=0 -> 2'b11.
REQ-034 Turbo-A reports 0,1,1,0,1 -> o_turbo[0] = 0,1,1,1,0; while latched, o_btn[0] toggles with period c_clk_hz/c_autofire_hz clocks (600000 at defaults).
REQ-035 Button held, then no valid for c_timeout_ms -> o_connected=0 and o_btn=0; the next valid restores both; valid coinciding with expiry -> no drop.
REQ-036 i_rstn pulsed low mid-report with turbo latched -> all outputs 0 immediately, and remain 0 until the next valid report.
